int_client: RTL and testbench

- Machine-mode trap sequencer feeding the pipeline flow controller.
- Detects ecall/ebreak, mret and external interrupts at the EX stage.
- Freezes the pipeline, writes mepc/mstatus/mcause through the CSR write port, then pulses the redirect:
  - trap entry: to mtvec
  - mret: to mepc
- Drives the controller's hold/interrupt-assert/interrupt-address inputs.

---
 rtl/int_client.sv | 181 ++++++++++++++++++
 tb/tb_int_client.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_client.sv
// Machine-mode trap sequencer: catches ecall/ebreak/mret/irq in EX,
// writes mepc/mstatus/mcause, then pulses a redirect to the controller.
module int_client #(
  parameter int CPU_WIDTH      = 32,
  parameter int INT_NUM        = 8,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INT_NUM-1:0]        int_flag_i,
  input  logic                      inst_ecall_i,
  input  logic                      inst_ebreak_i,
  input  logic                      inst_mret_i,
  input  logic [CPU_WIDTH-1:0]      inst_addr_i,
  input  logic                      jump_flag_i,
  input  logic [CPU_WIDTH-1:0]      jump_addr_i,
  input  logic                      div_busy_i,
  input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [CPU_WIDTH-1:0]      csr_wdata_o,
  output logic                      hold_flag_o,
  output logic [CPU_WIDTH-1:0]      int_addr_o,
  output logic                      int_assert_o
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MSTATUS,
    W_MCAUSE,
    ASSERT,
    MRET_MSTATUS,
    MRET_ASSERT
  } state_t;

  localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS =
    CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC =
    CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE =
    CSR_ADDR_WIDTH'(12'h342);

  state_t state, state_nxt;

  logic [CPU_WIDTH-1:0] epc_q;
  logic [CPU_WIDTH-1:0] cause_q;
  logic [CPU_WIDTH-1:0] mstatus_q;
  logic [CPU_WIDTH-1:0] mtvec_q;
  logic [CPU_WIDTH-1:0] mepc_q;

  logic sync_det;
  logic mret_det;
  logic async_det;
  logic any_det;
  logic [CPU_WIDTH-1:0] int_idx;
  logic [CPU_WIDTH-1:0] cause_nxt;
  logic [CPU_WIDTH-1:0] epc_nxt;

  // detections are made mutually exclusive to encode the priority
  always_comb begin
    sync_det  = 1'b0;
    mret_det  = 1'b0;
    async_det = 1'b0;
    if (state == IDLE) begin
      sync_det  = inst_ecall_i | inst_ebreak_i;
      mret_det  = inst_mret_i & ~sync_det;
      async_det = (|int_flag_i) & csr_mstatus_i[3] & ~div_busy_i
                & ~sync_det & ~inst_mret_i;
    end
    any_det = sync_det | mret_det | async_det;
  end

  // downward scan so the lowest set line wins
  always_comb begin
    int_idx = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (int_flag_i[i]) int_idx = CPU_WIDTH'(i);
    end
  end

  always_comb begin
    cause_nxt = CPU_WIDTH'(32'h8000_0010) + int_idx;
    epc_nxt   = jump_flag_i ? jump_addr_i : inst_addr_i;
    if (sync_det) begin
      epc_nxt   = inst_addr_i;
      cause_nxt = inst_ecall_i ? CPU_WIDTH'(32'd11)
                               : CPU_WIDTH'(32'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q     <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else if (any_det) begin
      epc_q     <= epc_nxt;
      cause_q   <= cause_nxt;
      mstatus_q <= csr_mstatus_i;
      mtvec_q   <= csr_mtvec_i;
      mepc_q    <= csr_mepc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          sync_det,
          async_det: state_nxt = W_MEPC;
          mret_det:  state_nxt = MRET_MSTATUS;
          default:   state_nxt = IDLE;
        endcase
      end
      W_MEPC:       state_nxt = W_MSTATUS;
      W_MSTATUS:    state_nxt = W_MCAUSE;
      W_MCAUSE:     state_nxt = ASSERT;
      ASSERT:       state_nxt = IDLE;
      MRET_MSTATUS: state_nxt = MRET_ASSERT;
      MRET_ASSERT:  state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    unique case (state)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = A_MEPC;
        csr_wdata_o = epc_q;
      end
      W_MSTATUS: begin
        csr_we_o       = 1'b1;
        csr_waddr_o    = A_MSTATUS;
        csr_wdata_o    = mstatus_q;
        csr_wdata_o[7] = mstatus_q[3];
        csr_wdata_o[3] = 1'b0;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = A_MCAUSE;
        csr_wdata_o = cause_q;
      end
      ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mtvec_q;
      end
      MRET_MSTATUS: begin
        csr_we_o       = 1'b1;
        csr_waddr_o    = A_MSTATUS;
        csr_wdata_o    = mstatus_q;
        csr_wdata_o[3] = mstatus_q[7];
        csr_wdata_o[7] = 1'b1;
      end
      MRET_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mepc_q;
      end
      default: ;
    endcase
  end

  assign hold_flag_o = (state != IDLE) | any_det;

endmodule

// File: tb/tb_int_client.sv
// Bench for int_client: queued expected CSR writes and redirects,
// popped by a negedge monitor; timing checked inline per scenario.
module tb_int_client;

  logic        clk;
  logic        rst_n;
  logic [7:0]  int_flag;
  logic        ecall, ebreak, mret;
  logic [31:0] inst_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        div_busy;
  logic [31:0] mtvec, mepc, mstatus;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        hold;
  logic [31:0] int_addr;
  logic        int_assert;

  int nchk;
  int nfail;

  logic [43:0] exp_csr[$];
  logic [31:0] exp_int[$];

  int_client dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .int_flag_i    (int_flag),
    .inst_ecall_i  (ecall),
    .inst_ebreak_i (ebreak),
    .inst_mret_i   (mret),
    .inst_addr_i   (inst_addr),
    .jump_flag_i   (jump_flag),
    .jump_addr_i   (jump_addr),
    .div_busy_i    (div_busy),
    .csr_mtvec_i   (mtvec),
    .csr_mepc_i    (mepc),
    .csr_mstatus_i (mstatus),
    .csr_we_o      (csr_we),
    .csr_waddr_o   (csr_waddr),
    .csr_wdata_o   (csr_wdata),
    .hold_flag_o   (hold),
    .int_addr_o    (int_addr),
    .int_assert_o  (int_assert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard consumer
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we) begin
        nchk++;
        if (exp_csr.size() == 0) begin
          nfail++;
          $display("FAIL csr_unexpected got %h<=%h want none",
                   csr_waddr, csr_wdata);
        end else begin
          logic [43:0] e;
          e = exp_csr.pop_front();
          if ({csr_waddr, csr_wdata} !== e) begin
            nfail++;
            $display("FAIL csr_write got %h<=%h want %h<=%h",
                     csr_waddr, csr_wdata, e[43:32], e[31:0]);
          end
        end
      end
      if (int_assert) begin
        nchk++;
        if (exp_int.size() == 0) begin
          nfail++;
          $display("FAIL int_unexpected got %h want none",
                   int_addr);
        end else begin
          logic [31:0] a;
          a = exp_int.pop_front();
          if (int_addr !== a) begin
            nfail++;
            $display("FAIL int_addr got %h want %h", int_addr, a);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_flag  = '0;
    ecall     = 1'b0;
    ebreak    = 1'b0;
    mret      = 1'b0;
    jump_flag = 1'b0;
    div_busy  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    idle_inputs();
    inst_addr = '0;
    jump_addr = '0;
    mtvec     = '0;
    mepc      = '0;
    mstatus   = '0;
    tick();
    tick();
    nchk++;
    if ({csr_we, csr_waddr, csr_wdata, hold, int_addr, int_assert}
        !== '0) begin
      nfail++;
      $display("FAIL reset_outputs got we=%b hold=%b ia=%b want 0",
               csr_we, hold, int_assert);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ecall();
    mtvec     = 32'h800;
    mstatus   = 32'h8;
    inst_addr = 32'h100;
    ecall     = 1'b1;
    exp_csr.push_back({12'h341, 32'h100});
    exp_csr.push_back({12'h300, 32'h80});
    exp_csr.push_back({12'h342, 32'hB});
    exp_int.push_back(32'h800);
    #1;
    nchk++;
    if (hold !== 1'b1) begin
      nfail++;
      $display("FAIL ecall_hold_detect got %b want 1", hold);
    end
    tick();
    ecall = 1'b0;
    tick();
    tick();
    tick();
    nchk++;
    if (int_assert !== 1'b1 || int_addr !== 32'h800) begin
      nfail++;
      $display("FAIL ecall_assert_c4 got %b/%h want 1/800",
               int_assert, int_addr);
    end
    tick();
    nchk++;
    if (hold !== 1'b0 || int_assert !== 1'b0) begin
      nfail++;
      $display("FAIL ecall_hold_drop got %b/%b want 0/0",
               hold, int_assert);
    end
  endtask

  task automatic test_irq_jump();
    mstatus   = 32'h8;
    inst_addr = 32'h1F0;
    jump_flag = 1'b1;
    jump_addr = 32'h200;
    int_flag  = 8'b0000_0100;
    exp_csr.push_back({12'h341, 32'h200});
    exp_csr.push_back({12'h300, 32'h80});
    exp_csr.push_back({12'h342, 32'h8000_0012});
    exp_int.push_back(32'h800);
    #1;
    nchk++;
    if (hold !== 1'b1) begin
      nfail++;
      $display("FAIL irq_hold_detect got %b want 1", hold);
    end
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    nchk++;
    if (int_assert !== 1'b1) begin
      nfail++;
      $display("FAIL irq_assert_c4 got %b want 1", int_assert);
    end
    tick();
    mstatus  = 32'h0;
    int_flag = 8'b0000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (hold !== 1'b0 || csr_we !== 1'b0) begin
        nfail++;
        $display("FAIL irq_mie0 got hold=%b we=%b want 0/0",
                 hold, csr_we);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_mret();
    mepc    = 32'h104;
    mstatus = 32'h80;
    mret    = 1'b1;
    exp_csr.push_back({12'h300, 32'h88});
    exp_int.push_back(32'h104);
    #1;
    nchk++;
    if (hold !== 1'b1) begin
      nfail++;
      $display("FAIL mret_hold got %b want 1", hold);
    end
    tick();
    mret = 1'b0;
    tick();
    nchk++;
    if (int_assert !== 1'b1 || int_addr !== 32'h104) begin
      nfail++;
      $display("FAIL mret_assert_c2 got %b/%h want 1/104",
               int_assert, int_addr);
    end
    tick();
    nchk++;
    if (hold !== 1'b0) begin
      nfail++;
      $display("FAIL mret_hold_drop got %b want 0", hold);
    end
  endtask

  task automatic test_div_busy();
    mstatus   = 32'h8;
    inst_addr = 32'h300;
    jump_flag = 1'b0;
    int_flag  = 8'h01;
    div_busy  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      nchk++;
      if (hold !== 1'b0) begin
        nfail++;
        $display("FAIL busy_no_hold cyc %0d got %b want 0", i, hold);
      end
      tick();
    end
    div_busy = 1'b0;
    exp_csr.push_back({12'h341, 32'h300});
    exp_csr.push_back({12'h300, 32'h80});
    exp_csr.push_back({12'h342, 32'h8000_0010});
    exp_int.push_back(32'h800);
    #1;
    nchk++;
    if (hold !== 1'b1) begin
      nfail++;
      $display("FAIL busy_drop_hold got %b want 1", hold);
    end
    tick();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_ebreak_irq();
    mstatus   = 32'h8;
    inst_addr = 32'h400;
    ebreak    = 1'b1;
    int_flag  = 8'hFF;
    exp_csr.push_back({12'h341, 32'h400});
    exp_csr.push_back({12'h300, 32'h80});
    exp_csr.push_back({12'h342, 32'h3});
    exp_int.push_back(32'h800);
    tick();
    ebreak = 1'b0;
    tick();
    tick();
    tick();
    nchk++;
    if (int_assert !== 1'b1) begin
      nfail++;
      $display("FAIL ebreak_assert got %b want 1", int_assert);
    end
    tick();
    mstatus = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      nchk++;
      if (hold !== 1'b0) begin
        nfail++;
        $display("FAIL irq_held_off got %b want 0", hold);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_abort();
    mstatus   = 32'h8;
    inst_addr = 32'h500;
    ecall     = 1'b1;
    exp_csr.push_back({12'h341, 32'h500});
    tick();
    ecall = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    nchk++;
    if (csr_we !== 1'b0 || hold !== 1'b0 || csr_waddr !== '0) begin
      nfail++;
      $display("FAIL abort_outputs got we=%b hold=%b want 0/0",
               csr_we, hold);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nchk++;
      if (hold !== 1'b0) begin
        nfail++;
        $display("FAIL abort_idle got hold=%b want 0", hold);
      end
    end
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    test_reset();
    test_ecall();
    test_irq_jump();
    test_mret();
    test_div_busy();
    test_ebreak_irq();
    test_reset_abort();
    tick();
    nchk++;
    if (exp_csr.size() != 0 || exp_int.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain got %0d/%0d left want 0/0",
               exp_csr.size(), exp_int.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
